// File: rtl/store_pkg.sv
// Shared encodings for the store data path: access sizes and sequencer states.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WAIT = 2'b10,
    ST_WR   = 2'b11
  } state_e;

  // Byte and halfword stores need a read-modify-write; word and reserved write directly.
  function automatic logic is_subword(input logic [1:0] sz);
    return (sz == SZ_HALF) || (sz == SZ_BYTE);
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational merge of new store data into the old memory word for sub-word stores.
module lane_merge
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] merged
);

  // Overlay the selected lane(s); halfword placement ignores addr_lo[0]
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]       = new_data[7:0];
      SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16]  = new_data[15:0];
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_data_unit.sv
// Store write-data path: source select, then direct word write or byte/half read-modify-write.
module store_data_unit
  import store_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic                      start,
  input  logic [1:0]                size,
  input  logic [1:0]                addr_lo,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   data_r;
  logic [1:0]          size_r;
  logic [1:0]          off_r;
  logic [DATA_W-1:0]   merged;

  // Source mux; out-of-range selects fall back to source 0
  always_comb begin
    sel_data = src_data[DATA_W-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) sel_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (mem_rdata),
    .new_data (data_r),
    .size     (size_r),
    .addr_lo  (off_r),
    .merged   (merged)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; WAIT exits when the latency counter has run down
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = is_subword(size) ? ST_RD : ST_WR;
      ST_RD:   state_nx = ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nx = ST_WR;
      ST_WR:   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Registered outputs, operand capture, latency counter and write-word formation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_wdata <= '0;
      data_r    <= '0;
      size_r    <= '0;
      off_r     <= '0;
      cnt       <= '0;
    end else begin
      mem_rd <= (state_nx == ST_RD);
      mem_wr <= (state_nx == ST_WR);
      done   <= (state_nx == ST_WR);
      busy   <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_r <= sel_data;
            size_r <= size;
            off_r  <= addr_lo;
            if (!is_subword(size)) mem_wdata <= sel_data;
          end
        end
        ST_RD: cnt <= CNT_W'(MEM_LAT - 1);
        ST_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           mem_wdata <= merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_data_unit.sv
// Directed bench for store_data_unit: default build, NUM_SRC=3 build and MEM_LAT=3 build.
module tb_store_data_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] src_data;
  logic [1:0]   src_sel;
  logic [2:0]   start;
  logic [1:0]   size;
  logic [1:0]   addr_lo;
  logic [31:0]  mem_rdata;
  logic [2:0]   rd_o, wr_o, dn_o, bz_o;
  logic [31:0]  wd_o [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_data_unit u0 (
    .clk(clk), .reset(reset), .src_data(src_data), .src_sel(src_sel), .start(start[0]),
    .size(size), .addr_lo(addr_lo), .mem_rdata(mem_rdata), .mem_rd(rd_o[0]), .mem_wr(wr_o[0]),
    .mem_wdata(wd_o[0]), .busy(bz_o[0]), .done(dn_o[0])
  );

  store_data_unit #(.NUM_SRC(3), .SEL_W(2)) u1 (
    .clk(clk), .reset(reset), .src_data(src_data[95:0]), .src_sel(src_sel), .start(start[1]),
    .size(size), .addr_lo(addr_lo), .mem_rdata(mem_rdata), .mem_rd(rd_o[1]), .mem_wr(wr_o[1]),
    .mem_wdata(wd_o[1]), .busy(bz_o[1]), .done(dn_o[1])
  );

  store_data_unit #(.MEM_LAT(3)) u2 (
    .clk(clk), .reset(reset), .src_data(src_data), .src_sel(src_sel), .start(start[2]),
    .size(size), .addr_lo(addr_lo), .mem_rdata(mem_rdata), .mem_rd(rd_o[2]), .mem_wr(wr_o[2]),
    .mem_wdata(wd_o[2]), .busy(bz_o[2]), .done(dn_o[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // One store on instance inst, started at a negedge (cycle 0); mem_rdata carries the
  // good word only across the edge that ends the last WAIT cycle.
  task automatic run_op(input int inst, input logic [1:0] sel, input int slot,
                        input logic [31:0] data, input logic [1:0] sz, input logic [1:0] al,
                        input logic [31:0] rd, input int lat, input logic [31:0] exp,
                        input int restart_c, input string nm);
    bit sub;
    int last;
    sub  = (sz == 2'b01) || (sz == 2'b10);
    last = sub ? 2 + lat : 1;
    src_data = {4{32'hA5A5A5A5}};
    src_data[slot*32 +: 32] = data;
    src_sel   = sel;
    size      = sz;
    addr_lo   = al;
    mem_rdata = ~rd;
    chk({nm, "_idle_busy"}, 32'(bz_o[inst]), 32'd0);
    start[inst] = 1'b1;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      start = '0;
      if (c == restart_c) start[inst] = 1'b1;
      if (c == 1) begin
        src_data = ~src_data;
        size     = ~size;
        addr_lo  = ~addr_lo;
      end
      mem_rdata = (sub && c == last - 1) ? rd : ~rd;
      chk($sformatf("%s_rd_c%0d", nm, c),   32'(rd_o[inst]), 32'(sub && c == 1));
      chk($sformatf("%s_wr_c%0d", nm, c),   32'(wr_o[inst]), 32'(c == last));
      chk($sformatf("%s_done_c%0d", nm, c), 32'(dn_o[inst]), 32'(c == last));
      chk($sformatf("%s_busy_c%0d", nm, c), 32'(bz_o[inst]), 32'(c <= last));
      if (c == last) chk({nm, "_wdata"}, wd_o[inst], exp);
    end
    start = '0;
  endtask

  typedef struct {
    logic [1:0]  sel;
    int          slot;
    logic [31:0] data;
    logic [1:0]  sz;
    logic [1:0]  al;
    logic [31:0] rd;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{2'd1, 1, 32'hDEADBEEF, 2'b00, 2'd0, 32'h11223344, 32'hDEADBEEF, "word"};
    tbl[1] = '{2'd0, 0, 32'h000000AB, 2'b10, 2'd2, 32'h11223344, 32'h11AB3344, "byte2"};
    tbl[2] = '{2'd0, 0, 32'h0000CAFE, 2'b01, 2'd3, 32'h11223344, 32'hCAFE3344, "half3"};
    tbl[3] = '{2'd2, 2, 32'h12345678, 2'b10, 2'd0, 32'h11223344, 32'h11223378, "byte0"};
    tbl[4] = '{2'd3, 3, 32'h000000FF, 2'b10, 2'd3, 32'h11223344, 32'hFF223344, "byte3"};
    tbl[5] = '{2'd1, 1, 32'h0000BEEF, 2'b01, 2'd0, 32'hAABBCCDD, 32'hAABBBEEF, "half0"};
    tbl[6] = '{2'd2, 2, 32'h01020304, 2'b11, 2'd1, 32'h55555555, 32'h01020304, "rsvd"};
    tbl[7] = '{2'd3, 3, 32'h1234ABCD, 2'b01, 2'd2, 32'h55667788, 32'hABCD7788, "half2"};

    reset = 1'b1;
    start = '0;
    src_data = '0;
    src_sel = '0;
    size = '0;
    addr_lo = '0;
    mem_rdata = '0;
    #1;
    chk("rst_rd",    32'(rd_o), 32'd0);
    chk("rst_wr",    32'(wr_o), 32'd0);
    chk("rst_done",  32'(dn_o), 32'd0);
    chk("rst_busy",  32'(bz_o), 32'd0);
    chk("rst_wdata", wd_o[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(0, tbl[i].sel, tbl[i].slot, tbl[i].data, tbl[i].sz, tbl[i].al,
             tbl[i].rd, 1, tbl[i].exp, 0, tbl[i].nm);
    end

    // Reset while WAITing aborts the byte store without a write
    src_data = {4{32'hA5A5A5A5}};
    src_data[31:0] = 32'h000000AB;
    src_sel = 2'd0; size = 2'b10; addr_lo = 2'd2; mem_rdata = 32'h11223344;
    start[0] = 1'b1;
    @(negedge clk);
    start = '0;
    @(negedge clk);
    chk("abort_busy_wait", 32'(bz_o[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rd",    32'(rd_o[0]), 32'd0);
    chk("abort_wr",    32'(wr_o[0]), 32'd0);
    chk("abort_done",  32'(dn_o[0]), 32'd0);
    chk("abort_busy",  32'(bz_o[0]), 32'd0);
    chk("abort_wdata", wd_o[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_nowr_c%0d", c), 32'(wr_o[0]), 32'd0);
      chk($sformatf("abort_idle_c%0d", c), 32'(bz_o[0]), 32'd0);
    end
    run_op(0, 2'd0, 0, 32'hFFFF00AB, 2'b10, 2'd1, 32'h00000000, 1, 32'h0000AB00, 0, "after_rst");

    // NUM_SRC=3: sel=3 falls back to source 0; a start while busy is dropped
    run_op(1, 2'd3, 0, 32'h00000055, 2'b10, 2'd1, 32'h11223344, 1, 32'h11225544, 1, "src3_busy");
    run_op(1, 2'd3, 0, 32'hCAFEF00D, 2'b00, 2'd0, 32'h0, 1, 32'hCAFEF00D, 0, "src3_word");

    // MEM_LAT=3: read data counts only at the edge that ends the third WAIT cycle
    run_op(2, 2'd0, 0, 32'h000000AB, 2'b10, 2'd0, 32'h11223344, 3, 32'h112233AB, 0, "lat3_byte");
    run_op(2, 2'd1, 1, 32'hDEADBEEF, 2'b00, 2'd0, 32'h0, 3, 32'hDEADBEEF, 0, "lat3_word");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
